// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic multiplier: FSM encoding,
// digit width and the digit-count helper.
package vedic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 2;

  function automatic int digit_count(input int width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/vedic_2_x_2_mul.sv
// 2x2-bit Vedic (Urdhva Tiryagbhyam) multiplier cell, purely combinational.
module vedic_2_x_2_mul (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] c
);

  logic cross0_s;
  logic cross1_s;
  logic carry1_s;
  logic top_s;

  // Vertical and crosswise partial products with their two-stage carry chain
  always_comb begin
    cross0_s = a[1] & b[0];
    cross1_s = a[0] & b[1];
    carry1_s = cross0_s & cross1_s;
    top_s    = a[1] & b[1];
    c[0]     = a[0] & b[0];
    c[1]     = cross0_s ^ cross1_s;
    c[2]     = top_s ^ carry1_s;
    c[3]     = top_s & carry1_s;
  end

endmodule

// File: rtl/vedic_seq_mul.sv
// Sequential WIDTH x WIDTH unsigned multiplier time-sharing one 2x2 Vedic cell.
// Optional VEDIC_SEQ_MUL_ZERO_SKIP_EN: zero operands bypass RUN (latency 1).
module vedic_seq_mul
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int D  = digit_count(WIDTH);
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(D - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);

  state_t               state_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CW-1:0]        i_r;
  logic [CW-1:0]        j_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic [2*WIDTH-1:0]   product_r;

  logic [DIGIT_W-1:0]   dig_a_s;
  logic [DIGIT_W-1:0]   dig_b_s;
  logic [3:0]           cell_s;
  logic [CW+1:0]        shift_s;
  logic [2*WIDTH-1:0]   pp_s;
  logic [2*WIDTH-1:0]   acc_next_s;
  logic                 last_pair_s;

  // Digit selection and shifted partial-product accumulation for the current pair
  always_comb begin
    dig_a_s     = a_r[{i_r, 1'b0} +: DIGIT_W];
    dig_b_s     = b_r[{j_r, 1'b0} +: DIGIT_W];
    shift_s     = {1'b0, i_r, 1'b0} + {1'b0, j_r, 1'b0};
    pp_s        = {{(2*WIDTH-4){1'b0}}, cell_s} << shift_s;
    acc_next_s  = acc_r + pp_s;
    last_pair_s = (i_r == LAST_C) && (j_r == LAST_C);
  end

  vedic_2_x_2_mul u_cell (
    .a (dig_a_s),
    .b (dig_b_s),
    .c (cell_s)
  );

  // Control FSM, digit counters, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      i_r         <= ZERO_C;
      j_r         <= ZERO_C;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      product_r   <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= b;
            acc_r      <= {(2*WIDTH){1'b0}};
            i_r        <= ZERO_C;
            j_r        <= ZERO_C;
            in_ready_r <= 1'b0;
`ifdef VEDIC_SEQ_MUL_ZERO_SKIP_EN
            if ((a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}})) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end
`else
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
`endif
          end
        end
        ST_RUN: begin
          acc_r <= acc_next_s;
          if (last_pair_s) begin
            state_r     <= ST_DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            product_r   <= acc_next_s;
            i_r         <= ZERO_C;
            j_r         <= ZERO_C;
          end else if (j_r == LAST_C) begin
            j_r <= ZERO_C;
            i_r <= i_r + ONE_C;
          end else begin
            j_r <= j_r + ONE_C;
          end
        end
        ST_DONE: begin
          // A zero-skip entry arrives with out_valid low; raise it one edge later.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            product_r   <= {(2*WIDTH){1'b0}};
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          acc_r       <= {(2*WIDTH){1'b0}};
          i_r         <= ZERO_C;
          j_r         <= ZERO_C;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          product_r   <= {(2*WIDTH){1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign product   = product_r;

endmodule

// File: tb/tb_vedic_seq_mul.sv
// Directed self-checking bench for vedic_seq_mul (WIDTH=8).
module tb_vedic_seq_mul;

  localparam int WIDTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] product;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int hs    = 0;
  int lat;
  int bcnt;
  int n;
  int hs_start;
  int stall;
  logic [WIDTH-1:0]   ra;
  logic [WIDTH-1:0]   rb;
  logic [2*WIDTH-1:0] exp_p;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) hs <= hs + 1;
  end

  vedic_seq_mul #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for in_ready, present one operand pair for one edge.
  task automatic start_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // From the negedge after acceptance, count edges until out_valid and busy samples.
  task automatic wait_out(output int l, output int bc);
    l  = 0;
    bc = 0;
    while (!out_valid && l < 60) begin
      if (busy) bc++;
      @(posedge clk);
      l++;
      @(negedge clk);
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = 8'd0;
    b = 8'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_product", 32'(product), 32'd0);

    // 3 x 2 with full timing
    start_op(8'd3, 8'd2);
    wait_out(lat, bcnt);
    chk("3x2_latency", 32'(lat), 32'd16);
    chk("3x2_busy_cycles", 32'(bcnt), 32'd16);
    chk("3x2_busy_done", 32'(busy), 32'd0);
    chk("3x2_product", 32'(product), 32'd6);
    @(negedge clk);
    chk("3x2_post_valid", 32'(out_valid), 32'd0);
    chk("3x2_post_ready", 32'(in_ready), 32'd1);
    chk("3x2_post_product", 32'(product), 32'd0);

    start_op(8'd255, 8'd255);
    wait_out(lat, bcnt);
    chk("255x255_product", 32'(product), 32'd65025);
    @(negedge clk);

    start_op(8'd170, 8'd85);
    wait_out(lat, bcnt);
    chk("170x85_product", 32'(product), 32'd14450);
    @(negedge clk);

    // Output stall with ignored input pulses
    out_ready = 1'b0;
    start_op(8'd15, 8'd17);
    wait_out(lat, bcnt);
    chk("stall_product0", 32'(product), 32'd255);
    for (int s = 0; s < 10; s++) begin
      in_valid = (s % 2 == 0);
      a = 8'd99;
      b = 8'd99;
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_product", 32'(product), 32'd255);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);

    // Reset in the middle of RUN
    start_op(8'd200, 8'd100);
    repeat (6) @(negedge clk);
    chk("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_product", 32'(product), 32'd0);
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    start_op(8'd12, 8'd12);
    wait_out(lat, bcnt);
    chk("12x12_latency", 32'(lat), 32'd16);
    chk("12x12_product", 32'(product), 32'd144);
    @(negedge clk);

    // Zero operand
    start_op(8'd0, 8'd77);
    wait_out(lat, bcnt);
`ifdef VEDIC_SEQ_MUL_ZERO_SKIP_EN
    chk("zero_latency", 32'(lat), 32'd1);
    chk("zero_busy_cycles", 32'(bcnt), 32'd0);
`else
    chk("zero_latency", 32'(lat), 32'd16);
    chk("zero_busy_cycles", 32'(bcnt), 32'd16);
`endif
    chk("zero_product", 32'(product), 32'd0);
    chk("zero_busy_done", 32'(busy), 32'd0);
    @(negedge clk);

    // Throughput with in_valid and out_ready held high: one product per 18 cycles
    a = 8'd5;
    b = 8'd6;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("tput_first_valid", 32'(out_valid), 32'd1);
    chk("tput_first_product", 32'(product), 32'd30);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (out_valid && n < 60);
    while (!out_valid && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("tput_interval", 32'(n), 32'd18);
    chk("tput_second_product", 32'(product), 32'd30);
    @(negedge clk);
    @(negedge clk);

    // Random operands with random output stalls
    hs_start = hs;
    for (int k = 0; k < 100; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp_p = 16'(ra) * 16'(rb);
      out_ready = 1'b0;
      start_op(ra, rb);
      wait_out(lat, bcnt);
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      chk("rand_product", 32'(product), 32'(exp_p));
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("rand_handshakes", 32'(hs - hs_start), 32'd100);
    chk("rand_final_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
